// File: rtl/audio_addr_sequencer_if.sv
// Sample-memory read request channel: address with valid/ready handshake.
// The sequencer drives the master side; the memory read controller takes the slave side.
interface audio_addr_sequencer_if #(
  parameter int ADDR_W = 23
) ();
  logic [ADDR_W-1:0] addr_dat;
  logic              addr_vld;
  logic              addr_rdy;

  modport master (
    output addr_dat,
    output addr_vld,
    input  addr_rdy
  );

  modport slave (
    input  addr_dat,
    input  addr_vld,
    output addr_rdy
  );
endinterface

// File: rtl/audio_addr_sequencer.sv
// Playback address stepper between runtime bounds; a tick yields a new request 1 cycle later.
// Address is held while addr_rdy is low; one tick is remembered and further ones flag overrun.
module audio_addr_sequencer #(
  parameter int ADDR_W = 23
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_play,
  input  logic                  i_direction_flag,
  input  logic                  i_loop_en,
  input  logic                  i_restart,
  input  logic [ADDR_W-1:0]     i_start_addr,
  input  logic [ADDR_W-1:0]     i_end_addr,
  audio_addr_sequencer_if.master rd_if,
  output logic                  o_done,
  output logic                  o_wrapped,
  output logic                  o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_STOPPED = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_hi;
  logic              r_pending;
  logic              r_restart_pend;
  logic              r_done;
  logic              r_wrapped;
  logic              r_overrun;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_lo_nxt;
  logic [ADDR_W-1:0] w_hi_nxt;
  logic              w_pending_nxt;
  logic              w_restart_pend_nxt;
  logic              w_done_nxt;
  logic              w_wrapped_nxt;
  logic              w_overrun_nxt;

  logic              w_load;
  logic              w_do_step;
  logic [ADDR_W-1:0] w_load_lo;
  logic [ADDR_W-1:0] w_load_hi;
  logic [ADDR_W-1:0] w_load_pt;
  logic [ADDR_W-1:0] w_step_addr;
  logic              w_step_wrap;
  logic              w_step_stop;

  // Inverted bounds collapse to a single-address window at start_addr.
  assign w_load_lo = i_start_addr;
  assign w_load_hi = (i_start_addr > i_end_addr) ? i_start_addr : i_end_addr;
  assign w_load_pt = i_direction_flag ? w_load_lo : w_load_hi;

  always_comb begin
    w_step_addr = r_addr;
    w_step_wrap = 1'b0;
    w_step_stop = 1'b0;
    if (i_direction_flag) begin
      if (r_addr < r_hi) begin
        w_step_addr = r_addr + ADDR_W'(1);
      end else if (i_loop_en) begin
        w_step_addr = r_lo;
        w_step_wrap = 1'b1;
      end else begin
        w_step_stop = 1'b1;
      end
    end else begin
      if (r_addr > r_lo) begin
        w_step_addr = r_addr - ADDR_W'(1);
      end else if (i_loop_en) begin
        w_step_addr = r_hi;
        w_step_wrap = 1'b1;
      end else begin
        w_step_stop = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_addr_nxt         = r_addr;
    w_lo_nxt           = r_lo;
    w_hi_nxt           = r_hi;
    w_pending_nxt      = r_pending;
    w_restart_pend_nxt = r_restart_pend;
    w_done_nxt         = 1'b0;
    w_wrapped_nxt      = 1'b0;
    w_overrun_nxt      = 1'b0;
    w_load             = 1'b0;
    w_do_step          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_play) w_load = 1'b1;
      end
      S_REQ: begin
        if (i_tick) begin
          w_pending_nxt = 1'b1;
          if (r_pending) w_overrun_nxt = 1'b1;
        end
        if (i_restart) w_restart_pend_nxt = 1'b1;
        if (rd_if.addr_rdy) begin
          // A tick landing on the accept cycle is served immediately rather than queued.
          if (r_restart_pend || i_restart) begin
            w_load = 1'b1;
          end else if (r_pending || i_tick) begin
            w_do_step = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_restart) begin
          w_load = 1'b1;
        end else if (i_play && i_tick) begin
          w_do_step = 1'b1;
        end
      end
      S_STOPPED: begin
        if (i_restart) begin
          w_load = 1'b1;
        end else if (!i_play) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_lo_nxt           = w_load_lo;
      w_hi_nxt           = w_load_hi;
      w_addr_nxt         = w_load_pt;
      w_pending_nxt      = 1'b0;
      w_restart_pend_nxt = 1'b0;
      w_state_nxt        = S_REQ;
    end else if (w_do_step) begin
      w_pending_nxt      = 1'b0;
      w_restart_pend_nxt = 1'b0;
      w_addr_nxt         = w_step_addr;
      if (w_step_stop) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_STOPPED;
      end else begin
        w_wrapped_nxt = w_step_wrap;
        w_state_nxt   = S_REQ;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_lo           <= '0;
      r_hi           <= '0;
      r_pending      <= 1'b0;
      r_restart_pend <= 1'b0;
      r_done         <= 1'b0;
      r_wrapped      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr         <= w_addr_nxt;
      r_lo           <= w_lo_nxt;
      r_hi           <= w_hi_nxt;
      r_pending      <= w_pending_nxt;
      r_restart_pend <= w_restart_pend_nxt;
      r_done         <= w_done_nxt;
      r_wrapped      <= w_wrapped_nxt;
      r_overrun      <= w_overrun_nxt;
    end
  end

  assign rd_if.addr_dat = r_addr;
  assign rd_if.addr_vld = (r_state == S_REQ);
  assign o_done         = r_done;
  assign o_wrapped      = r_wrapped;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_audio_addr_sequencer.sv
// Directed bench for audio_addr_sequencer: inputs change and outputs are checked on the falling edge.
module tb_audio_addr_sequencer;
  localparam int ADDR_W = 23;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_tick;
  logic              i_play;
  logic              i_direction_flag;
  logic              i_loop_en;
  logic              i_restart;
  logic [ADDR_W-1:0] i_start_addr;
  logic [ADDR_W-1:0] i_end_addr;
  logic              o_done;
  logic              o_wrapped;
  logic              o_overrun;

  int n_checks = 0;
  int n_errors = 0;

  audio_addr_sequencer_if #(.ADDR_W(ADDR_W)) rd_if ();

  audio_addr_sequencer #(.ADDR_W(ADDR_W)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_tick           (i_tick),
    .i_play           (i_play),
    .i_direction_flag (i_direction_flag),
    .i_loop_en        (i_loop_en),
    .i_restart        (i_restart),
    .i_start_addr     (i_start_addr),
    .i_end_addr       (i_end_addr),
    .rd_if            (rd_if.master),
    .o_done           (o_done),
    .o_wrapped        (o_wrapped),
    .o_overrun        (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic chk_out(input string tag, input int a, input bit vld, input bit dn,
                         input bit wr, input bit ov);
    chk({tag, ".addr"},    32'(rd_if.addr_dat), a);
    chk({tag, ".vld"},     32'(rd_if.addr_vld), 32'(vld));
    chk({tag, ".done"},    32'(o_done),         32'(dn));
    chk({tag, ".wrapped"}, 32'(o_wrapped),      32'(wr));
    chk({tag, ".overrun"}, 32'(o_overrun),      32'(ov));
  endtask

  // Tick from WAIT with ready high: request appears next cycle, accepted the cycle after.
  task automatic tick_adv(input string tag, input int a, input bit wr);
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
    chk_out(tag, a, 1'b1, 1'b0, wr, 1'b0);
    cyc();
    chk({tag, ".acc_vld"}, 32'(rd_if.addr_vld), 32'd0);
  endtask

  task automatic restart_to(input string tag, input int a);
    i_restart = 1'b1;
    cyc();
    i_restart = 1'b0;
    chk_out(tag, a, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    i_rst            = 1'b1;
    i_tick           = 1'b0;
    i_play           = 1'b0;
    i_direction_flag = 1'b1;
    i_loop_en        = 1'b1;
    i_restart        = 1'b0;
    i_start_addr     = '0;
    i_end_addr       = 23'd10;
    rd_if.addr_rdy   = 1'b1;
    cyc();
    cyc();
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Forward loop 0..10
    i_rst  = 1'b0;
    i_play = 1'b1;
    cyc();
    chk_out("fwd_load", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    for (int i = 1; i <= 12; i++) begin
      tick_adv($sformatf("fwd%0d", i), i % 11, i == 11);
    end

    // Backward loop 5..8, then direction flip at 6
    i_direction_flag = 1'b0;
    i_start_addr     = 23'd5;
    i_end_addr       = 23'd8;
    restart_to("bwd_load", 8);
    tick_adv("bwd7", 7, 1'b0);
    tick_adv("bwd6", 6, 1'b0);
    tick_adv("bwd5", 5, 1'b0);
    tick_adv("bwd_wrap", 8, 1'b1);
    tick_adv("bwd7b", 7, 1'b0);
    tick_adv("bwd6b", 6, 1'b0);
    i_direction_flag = 1'b1;
    tick_adv("flip7", 7, 1'b0);

    // One-shot forward 0..3
    i_loop_en    = 1'b0;
    i_start_addr = 23'd0;
    i_end_addr   = 23'd3;
    restart_to("os_load", 0);
    tick_adv("os1", 1, 1'b0);
    tick_adv("os2", 2, 1'b0);
    tick_adv("os3", 3, 1'b0);
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
    chk_out("os_done", 3, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_out("os_done_off", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      chk_out($sformatf("os_stopped%0d", i), 3, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    restart_to("os_restart", 0);

    // Backpressure at address 4
    i_loop_en  = 1'b1;
    i_end_addr = 23'd10;
    restart_to("bp_load", 0);
    tick_adv("bp1", 1, 1'b0);
    tick_adv("bp2", 2, 1'b0);
    tick_adv("bp3", 3, 1'b0);
    rd_if.addr_rdy = 1'b0;
    i_tick         = 1'b1;
    cyc();
    i_tick = 1'b0;
    chk_out("bp4", 4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      i_tick = (c == 2 || c == 4);
      cyc();
      i_tick = 1'b0;
      chk_out($sformatf("bp_hold%0d", c), 4, 1'b1, 1'b0, 1'b0, c == 4);
    end
    rd_if.addr_rdy = 1'b1;
    cyc();
    chk_out("bp_acc", 5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("bp_wait_vld", 32'(rd_if.addr_vld), 32'd0);

    // Pause in WAIT at 7
    tick_adv("ps6", 6, 1'b0);
    tick_adv("ps7", 7, 1'b0);
    i_play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      chk_out($sformatf("pause%0d", i), 7, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    i_play = 1'b1;
    tick_adv("resume8", 8, 1'b0);

    // Reset during a stalled request, then inverted bounds 9/2
    rd_if.addr_rdy = 1'b0;
    i_tick         = 1'b1;
    cyc();
    i_tick = 1'b0;
    chk_out("rq9", 9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    i_rst        = 1'b1;
    i_loop_en    = 1'b0;
    i_start_addr = 23'd9;
    i_end_addr   = 23'd2;
    cyc();
    chk_out("rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst          = 1'b0;
    rd_if.addr_rdy = 1'b1;
    cyc();
    chk_out("inv_load", 9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
    chk_out("inv_done", 9, 1'b0, 1'b1, 1'b0, 1'b0);
    i_play = 1'b0;
    cyc();
    chk_out("inv_idle", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    i_play    = 1'b1;
    i_loop_en = 1'b1;
    cyc();
    chk_out("inv_reload", 9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    tick_adv("inv_wrap", 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
